req_encoder: RTL and testbench
==============================

# req_encoder

Sequential 32-to-5 request encoder, the inverse of the register-file write-enable decoder: it collects one-hot/multi-hot request bits into a pending register and emits them one at a time as a 5-bit index over a valid/ready handshake. It sits between producers of per-register request strobes (e.g. writeback/scoreboard-release logic) and a consumer that needs a binary register address.

## Interface
- Parameters: none; widths fixed by RV32I, with N=32 requests and W=5 index bits.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  enables loading a new offer; pending collection continues regardless
- clr  in  1  synchronous flush of pending and any current offer
- req  in  32  request strobes; bit i set ⇒ request for index i
- idx  out  5  offered index (registered)
- valid  out  1  idx holds an offer (registered)
- ready  in  1  consumer accepts offer when valid && ready at a rising edge
- pending  out  32  current pending-request vector (registered)

## Operation
- The pending register accumulates requests on every edge: pending ← (pending & ~clear_mask) | req.
  - clear_mask is onehot(idx) when valid && ready at that edge, otherwise 0.
  - Set wins over clear: a req bit equal to the accepted idx stays pending.
- The FSM has two states, IDLE (valid=0) and OFFER (valid=1).
  - IDLE→OFFER: en=1 and candidates≠0. Load idx = pick(candidates), valid=1.
  - OFFER, !ready: hold idx and valid stable. Neither en nor new req affects them.
  - OFFER, ready: if en=1 and candidates≠0, load the next pick and stay in OFFER (back-to-back grant, one per cycle). Otherwise go to IDLE.
- candidates = pending & ~clear_mask. Same-cycle req is not visible until the next edge.
- pick is a priority selection; its policy is set by the macro below.
- A pending bit corresponding to the current offer is not offered twice. It is excluded from pick while valid=1.
- clr=1 (priority over everything): pending←0, valid←0, state←IDLE. The req of that cycle is dropped.
- rst_n low, including mid-offer: immediately sets pending=0, valid=0, idx=0, state IDLE.

## Timing
- Reset values: idx=0, valid=0, pending=0.
- Latency: req[i] sampled at edge E0 ⇒ pending[i]=1 after E0 ⇒ valid=1, idx=i after E1, if IDLE and en=1.
- Throughput: one index per cycle while ready=1 and candidates remain.
- All outputs are registered. There is no combinational path from req/ready to idx/valid.

## Configuration
- Macro: REQ_ENCODER_ROUND_ROBIN_EN.
- Defined: round-robin.
  - A 5-bit last-grant pointer is updated on each accept and reset to 31.
  - pick chooses the first candidate at index > last, wrapping 31→0.
- Undefined: fixed priority. pick selects the lowest-index candidate and no pointer exists.

## Structure
- Shared package (rv32i_pkg) holds N_REQ=32, IDX_W=5, and the FSM state enum {IDLE, OFFER}.
- Sub-module prio_pick is combinational.
  - Inputs: candidates[31:0], base[4:0].
  - Outputs: any, sel[4:0].
  - It computes the first set bit at or after base, wrapping.
  - Fixed-priority mode ties base to 0. Round-robin mode drives base = last+1 (mod 32).

## Test plan
- Reset: hold rst_n=0 mid-offer with idx=7 ⇒ idx=0, valid=0, pending=0 asynchronously, before any edge.
- Single request: req=32'h0000_0100 for one cycle with ready=1 ⇒ after 2 edges valid=1, idx=8, then one edge later valid=0 and pending=0.
- Backpressure: pending bits 3 and 9, ready=0 for 5 cycles ⇒ idx=3 holds stable.
  - Fixed priority: ready=1 ⇒ idx 3 then 9 on consecutive cycles.
  - Round-robin: last=31 ⇒ same order.
- Round-robin wrap (macro defined): pending bits 2, 30, 31 with last=29 ⇒ grant order 30, 31, 2.
- Set-wins: accept idx=5 while req[5]=1 in the same cycle ⇒ pending[5] stays 1 and idx 5 is offered again later.
- Flush/enable: en=0 with pending=32'hF ⇒ valid stays 0. Then clr=1 with req=32'h10 ⇒ pending=0, valid=0. Then en=1 ⇒ nothing offered.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared RV32I register-index definitions for the request encoder slice.
// Holds request/index widths, the encoder FSM state type and a one-hot helper.
package rv32i_pkg;
    localparam int N_REQ = 32;
    localparam int IDX_W = 5;

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_e;

    function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] i);
        return N_REQ'(1) << i;
    endfunction
endpackage

// File: rtl/req_encoder_if.sv
// Request/offer bundle between strobe producers, the encoder and the index consumer.
interface req_encoder_if;
    import rv32i_pkg::*;

    logic             en;
    logic             clr;
    logic [N_REQ-1:0] req;
    logic             ready;
    logic [IDX_W-1:0] idx;
    logic             valid;
    logic [N_REQ-1:0] pending;

    modport master (output en, clr, req, ready, input idx, valid, pending);
    modport slave  (input en, clr, req, ready, output idx, valid, pending);
endinterface

// File: rtl/req_encoder_prio_pick.sv
// Combinational wrapping priority pick: first set candidate at or after base.
module prio_pick
    import rv32i_pkg::*;
(
    input  logic [N_REQ-1:0] candidates,
    input  logic [IDX_W-1:0] base,
    output logic             any,
    output logic [IDX_W-1:0] sel
);
    logic [IDX_W-1:0] k;

    // Scan from the farthest offset down so the nearest hit is the last to win.
    always_comb begin
        any = 1'b0;
        sel = base;
        k   = base;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            k = base + IDX_W'(i);
            if (candidates[k]) begin
                any = 1'b1;
                sel = k;
            end
        end
    end
endmodule

// File: rtl/req_encoder.sv
// Sequential 32-to-5 request encoder with valid/ready offer handshake.
// Define REQ_ENCODER_ROUND_ROBIN_EN for round-robin pick; default is fixed priority.
module req_encoder
    import rv32i_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    req_encoder_if.slave  bus
);
    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [N_REQ-1:0] pending_q, pending_d;
    logic             accept;
    logic [N_REQ-1:0] clear_mask;
    logic [N_REQ-1:0] candidates;
    logic             any;
    logic [IDX_W-1:0] sel;
    logic [IDX_W-1:0] base;

    assign accept     = (state_q == OFFER) && bus.ready;
    assign clear_mask = accept ? onehot(idx_q) : '0;
    // The accepted index is masked out, so it is never re-picked on its own accept edge.
    assign candidates = pending_q & ~clear_mask;

`ifdef REQ_ENCODER_ROUND_ROBIN_EN
    logic [IDX_W-1:0] last_q, last_d;

    assign last_d = accept ? idx_q : last_q;
    assign base   = last_d + IDX_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) last_q <= '1;
        else        last_q <= last_d;
    end
`else
    assign base = '0;
`endif

    prio_pick u_pick (
        .candidates (candidates),
        .base       (base),
        .any        (any),
        .sel        (sel)
    );

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        pending_d = bus.clr ? '0 : ((pending_q & ~clear_mask) | bus.req);
        if (bus.clr) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.en && any) begin
                        state_d = OFFER;
                        idx_d   = sel;
                    end
                end
                OFFER: begin
                    if (bus.ready) begin
                        if (bus.en && any) idx_d   = sel;
                        else               state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            pending_q <= pending_d;
        end
    end

    assign bus.idx     = idx_q;
    assign bus.valid   = (state_q == OFFER);
    assign bus.pending = pending_q;
endmodule

// File: tb/tb_req_encoder.sv
// Directed, table-driven bench for req_encoder plus hand-written reset and wrap sequences.
module tb_req_encoder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    req_encoder_if bus ();

    req_encoder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        en;
        logic        clr;
        logic        ready;
        logic [31:0] req;
        logic        ev;
        logic [4:0]  ei;
        logic [31:0] ep;
    } vec_t;

    vec_t tbl[$];
    int   n_run  = 0;
    int   n_fail = 0;

    function automatic void add(input logic rst, input logic en, input logic clr,
                                input logic ready, input logic [31:0] req,
                                input logic ev, input logic [4:0] ei, input logic [31:0] ep);
        vec_t v;
        v.rst = rst; v.en = en; v.clr = clr; v.ready = ready; v.req = req;
        v.ev = ev; v.ei = ei; v.ep = ep;
        tbl.push_back(v);
    endfunction

    task automatic check(input string name, input logic ev, input logic [4:0] ei,
                         input logic [31:0] ep, input logic chk_idx);
        n_run++;
        if (bus.valid !== ev || bus.pending !== ep || (chk_idx && bus.idx !== ei)) begin
            n_fail++;
            $display("FAIL %s: valid=%0d idx=%0d pending=%h, required valid=%0d idx=%0d pending=%h",
                     name, bus.valid, bus.idx, bus.pending, ev, ei, ep);
        end
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    task automatic step(input logic en, input logic clr, input logic ready, input logic [31:0] req);
        bus.en = en; bus.clr = clr; bus.ready = ready; bus.req = req;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.en = 1'b1; bus.clr = 1'b0; bus.ready = 1'b0; bus.req = '0;

        // rst en clr rdy req | valid idx pending
        // single request, 2-edge latency then drained
        add(1, 1, 0, 1, 32'h0000_0100, 0, 0, 32'h0000_0100);
        add(0, 1, 0, 1, 32'h0,         1, 8, 32'h0000_0100);
        add(0, 1, 0, 1, 32'h0,         0, 0, 32'h0);
        // backpressure on bits 3 and 9
        add(1, 1, 0, 0, 32'h0000_0208, 0, 0, 32'h0000_0208);
        for (int i = 0; i < 5; i++)
            add(0, 1, 0, 0, 32'h0,     1, 3, 32'h0000_0208);
        add(0, 1, 0, 1, 32'h0,         1, 9, 32'h0000_0200);
        add(0, 1, 0, 1, 32'h0,         0, 0, 32'h0);
        // set wins over clear on accepted index 5
        add(1, 1, 0, 1, 32'h0000_0020, 0, 0, 32'h0000_0020);
        add(0, 1, 0, 0, 32'h0,         1, 5, 32'h0000_0020);
        add(0, 1, 0, 1, 32'h0000_0020, 0, 0, 32'h0000_0020);
        add(0, 1, 0, 1, 32'h0,         1, 5, 32'h0000_0020);
        add(0, 1, 0, 1, 32'h0,         0, 0, 32'h0);
        // enable low, then flush, then enable with nothing pending
        add(1, 0, 0, 1, 32'h0000_000F, 0, 0, 32'h0000_000F);
        add(0, 0, 0, 1, 32'h0,         0, 0, 32'h0000_000F);
        add(0, 0, 0, 1, 32'h0,         0, 0, 32'h0000_000F);
        add(0, 0, 1, 1, 32'h0000_0010, 0, 0, 32'h0);
        add(0, 1, 0, 1, 32'h0,         0, 0, 32'h0);
        add(0, 1, 0, 1, 32'h0,         0, 0, 32'h0);
        // flush during an offer
        add(0, 1, 0, 0, 32'h0000_0004, 0, 0, 32'h0000_0004);
        add(0, 1, 0, 0, 32'h0,         1, 2, 32'h0000_0004);
        add(0, 1, 1, 0, 32'h0000_0001, 0, 0, 32'h0);
        // back-to-back grants
        add(1, 1, 0, 1, 32'h0000_0007, 0, 0, 32'h0000_0007);
        add(0, 1, 0, 1, 32'h0,         1, 0, 32'h0000_0007);
        add(0, 1, 0, 1, 32'h0,         1, 1, 32'h0000_0006);
        add(0, 1, 0, 1, 32'h0,         1, 2, 32'h0000_0004);
        add(0, 1, 0, 1, 32'h0,         0, 0, 32'h0);

        // asynchronous reset while offering idx 7
        @(posedge clk); #1;
        pulse_reset();
        check("reset_initial", 1'b0, 5'd0, 32'h0, 1'b1);
        step(1, 0, 0, 32'h0000_0080);
        step(1, 0, 0, 32'h0);
        check("offer_7", 1'b1, 5'd7, 32'h0000_0080, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_mid_offer", 1'b0, 5'd0, 32'h0, 1'b1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        foreach (tbl[i]) begin
            if (tbl[i].rst) pulse_reset();
            step(tbl[i].en, tbl[i].clr, tbl[i].ready, tbl[i].req);
            check($sformatf("vec%0d", i), tbl[i].ev, tbl[i].ei, tbl[i].ep, tbl[i].ev);
        end

        // pick order for bits 2, 30, 31 after index 29 has been granted
        pulse_reset();
        step(1, 0, 0, 32'h2000_0000);
        step(1, 0, 0, 32'h0);
        check("offer_29", 1'b1, 5'd29, 32'h2000_0000, 1'b1);
        step(1, 0, 1, 32'hC000_0004);
        check("accept_29", 1'b0, 5'd0, 32'hC000_0004, 1'b0);
`ifdef REQ_ENCODER_ROUND_ROBIN_EN
        step(1, 0, 0, 32'h0);
        check("rr_first_30", 1'b1, 5'd30, 32'hC000_0004, 1'b1);
        step(1, 0, 1, 32'h0);
        check("rr_second_31", 1'b1, 5'd31, 32'h8000_0004, 1'b1);
        step(1, 0, 1, 32'h0);
        check("rr_wrap_2", 1'b1, 5'd2, 32'h0000_0004, 1'b1);
`else
        step(1, 0, 0, 32'h0);
        check("fp_first_2", 1'b1, 5'd2, 32'hC000_0004, 1'b1);
        step(1, 0, 1, 32'h0);
        check("fp_second_30", 1'b1, 5'd30, 32'hC000_0000, 1'b1);
        step(1, 0, 1, 32'h0);
        check("fp_third_31", 1'b1, 5'd31, 32'h8000_0000, 1'b1);
`endif
        step(1, 0, 1, 32'h0);
        check("drained", 1'b0, 5'd0, 32'h0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
